cache_arbiter: RTL

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache line reads and D-cache line reads/writebacks onto a 64-bit, 4-beat memory burst port.
// Build option: define CACHE_ARB_ROUND_ROBIN_EN for round-robin tie breaking (default: D side always wins).
module cache_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_read,
  input  logic [31:0]  i_addr,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [31:0]  d_addr,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_addr,
  output logic [63:0]  pmem_wdata,
  input  logic [63:0]  pmem_rdata,
  input  logic         pmem_resp
);

  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_e;

  state_e       state_q, state_d;
  logic [1:0]   k_q, k_d;
  logic [31:0]  base_q, base_d;
  logic [255:0] line_q, line_d;
  logic         dside_q, dside_d;   // 1 when the current/last burst serves the D side
  logic         d_req;
  logic         pick_dside;
  logic         in_burst;

  assign d_req = d_read | d_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;         // last_grant: 0 = I, 1 = D
  // On a tie, the side not served last wins.
  assign pick_dside = d_req & ~(i_read & last_d_q);
`else
  assign pick_dside = d_req;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    line_d  = line_q;
    dside_d = dside_q;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    last_d_d = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        k_d = 2'd0;
        if (pick_dside) begin
          dside_d = 1'b1;
          base_d  = d_addr & LINE_MASK;
          if (d_write) begin
            state_d = D_WR;
            line_d  = d_wdata;
          end else begin
            state_d = D_RD;
          end
        end else if (i_read) begin
          dside_d = 1'b0;
          base_d  = i_addr & LINE_MASK;
          state_d = I_RD;
        end
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        if (d_req | i_read) begin
          last_d_d = pick_dside;
        end
`endif
      end
      I_RD, D_RD, D_WR: begin
        if (pmem_resp) begin
          if (state_q != D_WR) begin
            line_d[{k_q, 6'd0} +: 64] = pmem_rdata;
          end
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      base_q  <= 32'd0;
      line_q  <= 256'd0;
      dside_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
      line_q  <= line_d;
      dside_q <= dside_d;
    end
  end

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`endif

  // All outputs decode from registered state so reset clears them immediately.
  assign pmem_read  = (state_q == I_RD) || (state_q == D_RD);
  assign pmem_write = (state_q == D_WR);
  assign in_burst   = pmem_read | pmem_write;
  assign pmem_addr  = in_burst ? (base_q + {27'd0, k_q, 3'd0}) : 32'd0;
  assign pmem_wdata = pmem_write ? line_q[{k_q, 6'd0} +: 64] : 64'd0;
  assign i_resp     = (state_q == DONE) && !dside_q;
  assign d_resp     = (state_q == DONE) && dside_q;
  assign i_rdata    = i_resp ? line_q : 256'd0;
  assign d_rdata    = d_resp ? line_q : 256'd0;

endmodule
